// File: rtl/amstrad_video_pkg.sv
// Shared types and limits for the Amstrad video fetch path.
package amstrad_video_pkg;

  localparam int unsigned WORD_BYTES_MAX  = 8;
  localparam int unsigned DELAY_MAX_LIMIT = 7;
  localparam int unsigned BYTE_W          = 8;

  typedef logic [BYTE_W-1:0] byte_t;

endpackage

// File: rtl/vram_byte_delay.sv
// Programmable byte delay line: DELAY_MAX-deep history shifted on each sample,
// with a clamped tap select (tap 0 = undelayed input byte).
module vram_byte_delay
  import amstrad_video_pkg::*;
#(
  parameter int unsigned DELAY_MAX = 2,
  parameter int unsigned DW_SEL    = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              shift_en,
  input  logic              mask,
  input  byte_t             din,
  input  logic [DW_SEL-1:0] delay_sel,
  output byte_t             tap_c
);

  localparam logic [DW_SEL-1:0] DSEL_MAX = DW_SEL'(DELAY_MAX);

  byte_t             hist_q [DELAY_MAX];
  byte_t             hist_d [DELAY_MAX];
  logic [DW_SEL-1:0] dly_c;

  always_comb begin
    dly_c = (delay_sel > DSEL_MAX) ? DSEL_MAX : delay_sel;
  end

  // Tap reads the history as it stood before this sample's shift.
  always_comb begin
    tap_c = din;
    for (int unsigned k = 0; k < DELAY_MAX; k++) begin
      if (dly_c == DW_SEL'(k + 1)) tap_c = hist_q[k];
    end
  end

  always_comb begin
    hist_d = hist_q;
    if (shift_en) begin
      hist_d[0] = mask ? '0 : din;
      for (int unsigned k = 1; k < DELAY_MAX; k++) begin
        hist_d[k] = hist_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < DELAY_MAX; k++) hist_q[k] <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

endmodule

// File: rtl/vram_byte_sequencer.sv
// Splits a wide VRAM word into a CAS-paced byte stream for the gate array.
// Optional VRAM_SEQ_STATS_EN adds fetch_cnt / ovr_cnt statistics outputs.
module vram_byte_sequencer
  import amstrad_video_pkg::*;
#(
  parameter int unsigned WORD_BYTES = 2,
  parameter int unsigned DELAY_MAX  = 2,
  parameter int unsigned DW_SEL     = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cpu_n,
  input  logic                    ras_n,
  input  logic                    cas_n,
  input  logic                    de,
  input  logic                    mask_en,
  input  logic [DW_SEL-1:0]       delay_sel,
  input  logic [8*WORD_BYTES-1:0] vram_din,
  output logic [7:0]              vram_d,
  output logic                    byte_stb,
  output logic [2:0]              byte_idx,
  output logic                    overrun
`ifdef VRAM_SEQ_STATS_EN
  ,
  output logic [15:0]             fetch_cnt,
  output logic [7:0]              ovr_cnt
`endif
);

  localparam int unsigned IDX_W    = 3;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_BYTES - 1);

  logic             cas_n_old_q;
  byte_t            vram_d_q, vram_d_d;
  logic             byte_stb_q, byte_stb_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             overrun_q, overrun_d;

  logic  sample_c;
  logic  advance_c;
  byte_t byte_c;
  byte_t tap_c;

  // CAS falling edge samples a byte, CAS rising edge advances the index.
  always_comb begin
    sample_c  = ~ras_n & ~cas_n &  cas_n_old_q & cpu_n;
    advance_c = ~ras_n &  cas_n & ~cas_n_old_q & cpu_n;
  end

  always_comb begin
    byte_c = '0;
    for (int unsigned i = 0; i < WORD_BYTES; i++) begin
      if (idx_q == IDX_W'(i)) byte_c = vram_din[8*i +: 8];
    end
  end

  vram_byte_delay #(
    .DELAY_MAX (DELAY_MAX),
    .DW_SEL    (DW_SEL)
  ) u_delay (
    .clk       (clk),
    .reset     (reset),
    .shift_en  (sample_c),
    .mask      (mask_en & ~de),
    .din       (byte_c),
    .delay_sel (delay_sel),
    .tap_c     (tap_c)
  );

  // Index saturates on the last byte; extra advances flag an overrun.
  always_comb begin
    idx_d      = idx_q;
    overrun_d  = 1'b0;
    byte_stb_d = sample_c;
    vram_d_d   = vram_d_q;
    if (!cpu_n) begin
      idx_d = '0;
    end else if (advance_c) begin
      if (idx_q < IDX_LAST) idx_d = idx_q + IDX_W'(1);
      else                  overrun_d = 1'b1;
    end
    if (sample_c) vram_d_d = tap_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cas_n_old_q <= 1'b1;
      vram_d_q    <= '0;
      byte_stb_q  <= 1'b0;
      idx_q       <= '0;
      overrun_q   <= 1'b0;
    end else begin
      cas_n_old_q <= cas_n;
      vram_d_q    <= vram_d_d;
      byte_stb_q  <= byte_stb_d;
      idx_q       <= idx_d;
      overrun_q   <= overrun_d;
    end
  end

  assign vram_d   = vram_d_q;
  assign byte_stb = byte_stb_q;
  assign byte_idx = idx_q;
  assign overrun  = overrun_q;

`ifdef VRAM_SEQ_STATS_EN
  logic [15:0] fetch_cnt_q, fetch_cnt_d;
  logic [7:0]  ovr_cnt_q, ovr_cnt_d;

  // Fetch count wraps; overrun count sticks at its maximum.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    ovr_cnt_d   = ovr_cnt_q;
    if (sample_c) fetch_cnt_d = fetch_cnt_q + 16'd1;
    if (overrun_d && (ovr_cnt_q != 8'hFF)) ovr_cnt_d = ovr_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      ovr_cnt_q   <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      ovr_cnt_q   <= ovr_cnt_d;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign ovr_cnt   = ovr_cnt_q;
`endif

endmodule

// File: tb/tb_vram_byte_sequencer.sv
// Directed bench for vram_byte_sequencer: 2-byte and 4-byte instances share strobes.
module tb_vram_byte_sequencer;

  logic        clk;
  logic        reset, cpu_n, ras_n, cas_n, de, mask_en;
  logic [2:0]  delay_sel;
  logic [15:0] din2;
  logic [31:0] din4;
  logic [7:0]  vram_d2, vram_d4;
  logic        stb2, stb4, ovr2, ovr4;
  logic [2:0]  idx2, idx4;
`ifdef VRAM_SEQ_STATS_EN
  logic [15:0] fetch2, fetch4;
  logic [7:0]  oc2, oc4;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] s_d2, s_d4;
  logic       s_stb2, s_stb4, a_ovr2, a_ovr4;
  logic [2:0] a_idx2, a_idx4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vram_byte_sequencer #(.WORD_BYTES(2), .DELAY_MAX(2), .DW_SEL(3)) u_dut2 (
    .clk(clk), .reset(reset), .cpu_n(cpu_n), .ras_n(ras_n), .cas_n(cas_n),
    .de(de), .mask_en(mask_en), .delay_sel(delay_sel), .vram_din(din2),
    .vram_d(vram_d2), .byte_stb(stb2), .byte_idx(idx2), .overrun(ovr2)
`ifdef VRAM_SEQ_STATS_EN
    , .fetch_cnt(fetch2), .ovr_cnt(oc2)
`endif
  );

  vram_byte_sequencer #(.WORD_BYTES(4), .DELAY_MAX(2), .DW_SEL(3)) u_dut4 (
    .clk(clk), .reset(reset), .cpu_n(cpu_n), .ras_n(ras_n), .cas_n(cas_n),
    .de(de), .mask_en(mask_en), .delay_sel(delay_sel), .vram_din(din4),
    .vram_d(vram_d4), .byte_stb(stb4), .byte_idx(idx4), .overrun(ovr4)
`ifdef VRAM_SEQ_STATS_EN
    , .fetch_cnt(fetch4), .ovr_cnt(oc4)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One CAS pulse; captures outputs after the sample edge and after the advance edge.
  task automatic cas_pulse(input bit end_ras);
    @(negedge clk) cas_n = 1'b0;
    @(negedge clk);
    s_d2 = vram_d2; s_d4 = vram_d4; s_stb2 = stb2; s_stb4 = stb4;
    cas_n = 1'b1;
    if (end_ras) ras_n = 1'b1;
    @(negedge clk);
    a_ovr2 = ovr2; a_ovr4 = ovr4; a_idx2 = idx2; a_idx4 = idx4;
  endtask

  task automatic do_reset();
    @(negedge clk) begin reset = 1'b1; cpu_n = 1'b1; ras_n = 1'b1; cas_n = 1'b1; end
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic new_word();
    @(negedge clk) begin cpu_n = 1'b0; ras_n = 1'b1; end
    @(negedge clk) begin cpu_n = 1'b1; ras_n = 1'b0; end
  endtask

  initial begin
    reset = 1'b1; cpu_n = 1'b1; ras_n = 1'b1; cas_n = 1'b1;
    de = 1'b1; mask_en = 1'b0; delay_sel = 3'd0; din2 = '0; din4 = '0;
    repeat (2) @(negedge clk);
    check("rst_vram_d", 32'(vram_d2), 32'h0);
    check("rst_stb",    32'(stb2),    32'h0);
    check("rst_idx",    32'(idx2),    32'h0);
    check("rst_ovr",    32'(ovr2),    32'h0);
    check("rst_idx4",   32'(idx4),    32'h0);
    reset = 1'b0;

    // Legacy non-filtered two-byte fetch
    din2 = 16'hA55A;
    @(negedge clk) ras_n = 1'b0;
    cas_pulse(1'b0);
    check("legacy_stb0", 32'(s_stb2), 32'h1);
    check("legacy_b0",   32'(s_d2),   32'h5A);
    check("legacy_ovr0", 32'(a_ovr2), 32'h0);
    check("legacy_idx0", 32'(a_idx2), 32'h1);
    cas_pulse(1'b1);
    check("legacy_stb1", 32'(s_stb2), 32'h1);
    check("legacy_b1",   32'(s_d2),   32'hA5);
    check("legacy_ovr1", 32'(a_ovr2), 32'h0);
    check("legacy_hold", 32'(vram_d2), 32'hA5);
    check("legacy_stb_low", 32'(stb2), 32'h0);

    // Delay 1 with display-enable masking
    do_reset();
    delay_sel = 3'd1; mask_en = 1'b1; de = 1'b1; din2 = 16'h2211;
    new_word();
    cas_pulse(1'b0); check("dly1_b0", 32'(s_d2), 32'h00);
    cas_pulse(1'b1); check("dly1_b1", 32'(s_d2), 32'h11);
    de = 1'b0; din2 = 16'h4433;
    new_word();
    cas_pulse(1'b0); check("dly1_b2", 32'(s_d2), 32'h22);
    cas_pulse(1'b1); check("dly1_b3", 32'(s_d2), 32'h00);
    check("dly1_stb", 32'(s_stb2), 32'h1);
    de = 1'b1;

    // Saturation on the 4-byte instance
    do_reset();
    delay_sel = 3'd0; mask_en = 1'b0; din4 = 32'h44332211;
    new_word();
    for (int i = 0; i < 5; i++) begin
      cas_pulse(1'b0);
      check($sformatf("sat_stb%0d", i), 32'(s_stb4), 32'h1);
      check($sformatf("sat_b%0d", i),   32'(s_d4), (i < 4) ? 32'(8'h11 * (i + 1)) : 32'h44);
      check($sformatf("sat_ovr%0d", i), 32'(a_ovr4), (i >= 3) ? 32'h1 : 32'h0);
      check($sformatf("sat_idx%0d", i), 32'(a_idx4), (i < 3) ? 32'(i + 1) : 32'h3);
    end
    @(negedge clk) ras_n = 1'b1;
    check("sat_ovr_pulse", 32'(ovr4), 32'h0);

    // cpu_n low wins over a coincident CAS falling edge
    din2 = 16'hA55A;
    new_word();
    cas_pulse(1'b0);
    check("prio_pre_idx", 32'(a_idx2), 32'h1);
    @(negedge clk) begin cas_n = 1'b0; cpu_n = 1'b0; end
    @(negedge clk);
    check("prio_stb", 32'(stb2), 32'h0);
    check("prio_idx", 32'(idx2), 32'h0);
    cas_n = 1'b1;
    @(negedge clk) cpu_n = 1'b1;
    check("prio_ovr", 32'(ovr2), 32'h0);
    check("prio_idx_hold", 32'(idx2), 32'h0);

    // Reset in the middle of a word
    din2 = 16'hBEEF;
    new_word();
    cas_pulse(1'b0);
    check("rmid_b0", 32'(s_d2), 32'hEF);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    check("rmid_vram_d", 32'(vram_d2), 32'h0);
    check("rmid_idx",    32'(idx2),    32'h0);
    check("rmid_stb",    32'(stb2),    32'h0);
    reset = 1'b0;
    din2 = 16'h1234;
    cas_pulse(1'b0); check("rmid_n0", 32'(s_d2), 32'h34);
    cas_pulse(1'b1); check("rmid_n1", 32'(s_d2), 32'h12);

    // delay_sel above DELAY_MAX clamps to a 2-byte delay
    do_reset();
    delay_sel = 3'd7; mask_en = 1'b0; de = 1'b1; din2 = 16'h2211;
    new_word();
    cas_pulse(1'b0); check("clamp_b0", 32'(s_d2), 32'h00);
    cas_pulse(1'b1); check("clamp_b1", 32'(s_d2), 32'h00);
    din2 = 16'h4433;
    new_word();
    cas_pulse(1'b0); check("clamp_b2", 32'(s_d2), 32'h11);
    cas_pulse(1'b1); check("clamp_b3", 32'(s_d2), 32'h22);

`ifdef VRAM_SEQ_STATS_EN
    check("stats_fetch2", 32'(fetch2), 32'd4);
    check("stats_fetch4", 32'(fetch4), 32'd4);
    check("stats_ovr2",   32'(oc2),    32'd0);
    check("stats_ovr4",   32'(oc4),    32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
